// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared constants and FSM encoding for the PC fetch slice
package pc_pkg;

    localparam int ADDR_W = 32;
    localparam logic [ADDR_W-1:0] PC_STEP = 32'd4;

    typedef enum logic {
        S_FETCH = 1'b0,
        S_ISSUE = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/pc_next_sel.sv
// rtl/pc_next_sel.sv - next-PC selection (increment, redirect, alignment/trap); PC_MISALIGN_TRAP_EN enables the trap
module pc_next_sel
    import pc_pkg::*;
#(
    parameter logic [ADDR_W-1:0] TRAP_VECTOR = 32'h0000_0100
) (
    input  logic [ADDR_W-1:0] i_pc,
    input  logic              i_branch,
    input  logic [ADDR_W-1:0] i_target,
    output logic [ADDR_W-1:0] o_next_pc,
    output logic              o_misalign
);

`ifdef PC_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic w_misaligned;

    // A misaligned taken redirect only diverts to the trap vector when trapping is built in;
    // otherwise the low address bits are simply dropped.
    assign w_misaligned = TRAP_EN && i_branch && (i_target[1:0] != 2'b00);

    // Priority: trap, then redirect (word aligned), then sequential step wrapping mod 2^32
    always_comb begin
        o_next_pc = i_pc + PC_STEP;
        if (w_misaligned) begin
            o_next_pc = TRAP_VECTOR;
        end else if (i_branch) begin
            o_next_pc = {i_target[ADDR_W-1:2], 2'b00};
        end
    end

    assign o_misalign = w_misaligned;

endmodule

// File: rtl/pc_fetch.sv
// rtl/pc_fetch.sv - two-state fetch/issue program counter unit; PC_MISALIGN_TRAP_EN selects misaligned-redirect trapping
module pc_fetch
    import pc_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [ADDR_W-1:0] TRAP_VECTOR  = 32'h0000_0100
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              BranchMux,
    input  logic [ADDR_W-1:0] BranchTarget,
    input  logic              Stall,
    input  logic              ImemReady,
    input  logic [31:0]       ImemData,
    output logic              ImemReq,
    output logic [ADDR_W-1:0] ImemAddr,
    output logic [ADDR_W-1:0] Pc,
    output logic [31:0]       Instr,
    output logic              InstrValid,
    output logic [31:0]       InstrCount,
    output logic              MisalignErr
);

    fetch_state_t      r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [31:0]       r_instr;
    logic [31:0]       r_count;
    logic              r_misalign;
    logic              r_req;
    logic              r_valid;

    logic [ADDR_W-1:0] w_next_pc;
    logic              w_misalign;

    pc_next_sel #(
        .TRAP_VECTOR (TRAP_VECTOR)
    ) u_next_sel (
        .i_pc       (r_pc),
        .i_branch   (BranchMux),
        .i_target   (BranchTarget),
        .o_next_pc  (w_next_pc),
        .o_misalign (w_misalign)
    );

    // Fetch/issue FSM with registered request and valid flags
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state    <= S_FETCH;
            r_pc       <= RESET_VECTOR;
            r_instr    <= 32'd0;
            r_count    <= 32'd0;
            r_misalign <= 1'b0;
            r_req      <= 1'b1;
            r_valid    <= 1'b0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (ImemReady) begin
                        r_instr <= ImemData;
                        r_state <= S_ISSUE;
                        r_req   <= 1'b0;
                        r_valid <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    if (!Stall) begin
                        r_pc       <= w_next_pc;
                        r_count    <= r_count + 32'd1;
                        r_misalign <= r_misalign | w_misalign;
                        r_state    <= S_FETCH;
                        r_req      <= 1'b1;
                        r_valid    <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_FETCH;
                    r_req   <= 1'b1;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    // Request is suppressed while reset is held so an abandoned fetch never reaches memory
    assign ImemReq     = r_req & ~Reset;
    assign ImemAddr    = r_pc;
    assign Pc          = r_pc;
    assign Instr       = r_instr;
    assign InstrValid  = r_valid;
    assign InstrCount  = r_count;
    assign MisalignErr = r_misalign;

endmodule

// File: tb/tb_pc_fetch.sv
// tb/tb_pc_fetch.sv - directed self-checking bench for pc_fetch
module tb_pc_fetch;

    logic        Clk;
    logic        Reset;
    logic        BranchMux;
    logic [31:0] BranchTarget;
    logic        Stall;
    logic        ImemReady;
    logic [31:0] ImemData;
    logic        ImemReq;
    logic [31:0] ImemAddr;
    logic [31:0] Pc;
    logic [31:0] Instr;
    logic        InstrValid;
    logic [31:0] InstrCount;
    logic        MisalignErr;

    int n_cmp = 0;
    int n_err = 0;

    pc_fetch dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .BranchMux    (BranchMux),
        .BranchTarget (BranchTarget),
        .Stall        (Stall),
        .ImemReady    (ImemReady),
        .ImemData     (ImemData),
        .ImemReq      (ImemReq),
        .ImemAddr     (ImemAddr),
        .Pc           (Pc),
        .Instr        (Instr),
        .InstrValid   (InstrValid),
        .InstrCount   (InstrCount),
        .MisalignErr  (MisalignErr)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1; BranchMux = 1'b0; BranchTarget = 32'h0; Stall = 1'b0;
        ImemReady = 1'b1; ImemData = 32'h1111_1111;
        tick();
        tick();
        n_cmp++; if (ImemReq !== 1'b0) begin n_err++; $display("FAIL rst_req got %0b exp 0", ImemReq); end
        n_cmp++; if (Pc !== 32'h0) begin n_err++; $display("FAIL rst_pc got %h exp 0", Pc); end
        n_cmp++; if (Instr !== 32'h0) begin n_err++; $display("FAIL rst_instr got %h exp 0", Instr); end
        n_cmp++; if (InstrValid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %0b exp 0", InstrValid); end
        n_cmp++; if (InstrCount !== 32'h0) begin n_err++; $display("FAIL rst_count got %0d exp 0", InstrCount); end
        n_cmp++; if (MisalignErr !== 1'b0) begin n_err++; $display("FAIL rst_mis got %0b exp 0", MisalignErr); end
        Reset = 1'b0;
        #1;
        n_cmp++; if (ImemReq !== 1'b1) begin n_err++; $display("FAIL first_req got %0b exp 1", ImemReq); end
        n_cmp++; if (ImemAddr !== 32'h0) begin n_err++; $display("FAIL first_addr got %h exp 0", ImemAddr); end
        tick();
        n_cmp++; if (InstrValid !== 1'b1) begin n_err++; $display("FAIL first_valid got %0b exp 1", InstrValid); end
        n_cmp++; if (Instr !== 32'h1111_1111) begin n_err++; $display("FAIL first_instr got %h exp 11111111", Instr); end
        n_cmp++; if (ImemReq !== 1'b0) begin n_err++; $display("FAIL issue_req got %0b exp 0", ImemReq); end
    endtask

    task automatic test_sequential();
        for (int i = 1; i <= 2; i++) begin
            tick();
            n_cmp++; if (Pc !== 32'(4 * i)) begin n_err++; $display("FAIL seq_pc%0d got %h exp %h", i, Pc, 32'(4 * i)); end
            n_cmp++; if (InstrCount !== 32'(i)) begin n_err++; $display("FAIL seq_cnt%0d got %0d exp %0d", i, InstrCount, i); end
            n_cmp++; if (InstrValid !== 1'b0 || ImemReq !== 1'b1) begin n_err++; $display("FAIL seq_fetch%0d got v=%0b r=%0b exp v=0 r=1", i, InstrValid, ImemReq); end
            tick();
            n_cmp++; if (InstrValid !== 1'b1) begin n_err++; $display("FAIL seq_valid%0d got %0b exp 1", i, InstrValid); end
        end
    endtask

    task automatic test_branch();
        BranchMux = 1'b1; BranchTarget = 32'h40;
        tick();
        n_cmp++; if (ImemAddr !== 32'h40) begin n_err++; $display("FAIL br_addr got %h exp 40", ImemAddr); end
        n_cmp++; if (InstrCount !== 32'd3) begin n_err++; $display("FAIL br_cnt got %0d exp 3", InstrCount); end
        // In fetch, redirect and stall must be ignored
        BranchTarget = 32'h80; Stall = 1'b1; ImemReady = 1'b0;
        tick();
        n_cmp++; if (Pc !== 32'h40 || ImemReq !== 1'b1) begin n_err++; $display("FAIL br_ign got pc=%h r=%0b exp pc=40 r=1", Pc, ImemReq); end
        BranchMux = 1'b0; Stall = 1'b0;
    endtask

    task automatic test_wait_stall();
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++; if (ImemAddr !== 32'h40 || ImemReq !== 1'b1 || InstrValid !== 1'b0) begin
                n_err++; $display("FAIL wait%0d got a=%h r=%0b v=%0b exp a=40 r=1 v=0", i, ImemAddr, ImemReq, InstrValid);
            end
        end
        ImemReady = 1'b1; ImemData = 32'h00A0_0093;
        tick();
        n_cmp++; if (Instr !== 32'h00A0_0093 || InstrValid !== 1'b1) begin n_err++; $display("FAIL wait_done got i=%h v=%0b exp i=00a00093 v=1", Instr, InstrValid); end
        Stall = 1'b1; BranchMux = 1'b1; BranchTarget = 32'h200; ImemData = 32'hDEAD_BEEF;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++; if (Instr !== 32'h00A0_0093 || Pc !== 32'h40 || InstrValid !== 1'b1 || InstrCount !== 32'd3) begin
                n_err++; $display("FAIL stall%0d got i=%h pc=%h v=%0b c=%0d exp i=00a00093 pc=40 v=1 c=3", i, Instr, Pc, InstrValid, InstrCount);
            end
        end
        Stall = 1'b0; BranchMux = 1'b0;
        tick();
        n_cmp++; if (Pc !== 32'h44 || InstrCount !== 32'd4) begin n_err++; $display("FAIL unstall got pc=%h c=%0d exp pc=44 c=4", Pc, InstrCount); end
    endtask

    task automatic test_wrap_misalign();
        logic [31:0] exp_pc;
        logic        exp_mis;
`ifdef PC_MISALIGN_TRAP_EN
        exp_pc = 32'h100; exp_mis = 1'b1;
`else
        exp_pc = 32'h40;  exp_mis = 1'b0;
`endif
        tick();
        BranchMux = 1'b1; BranchTarget = 32'hFFFF_FFFC;
        tick();
        n_cmp++; if (Pc !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL top_pc got %h exp fffffffc", Pc); end
        BranchMux = 1'b0;
        tick();
        tick();
        n_cmp++; if (Pc !== 32'h0 || InstrCount !== 32'd6) begin n_err++; $display("FAIL wrap got pc=%h c=%0d exp pc=0 c=6", Pc, InstrCount); end
        tick();
        BranchMux = 1'b1; BranchTarget = 32'h42;
        tick();
        n_cmp++; if (Pc !== exp_pc) begin n_err++; $display("FAIL mis_pc got %h exp %h", Pc, exp_pc); end
        n_cmp++; if (MisalignErr !== exp_mis) begin n_err++; $display("FAIL mis_flag got %0b exp %0b", MisalignErr, exp_mis); end
        BranchMux = 1'b0;
        tick();
        tick();
        n_cmp++; if (MisalignErr !== exp_mis) begin n_err++; $display("FAIL mis_sticky got %0b exp %0b", MisalignErr, exp_mis); end
    endtask

    task automatic test_reset_midfetch();
        ImemReady = 1'b0;
        tick();
        n_cmp++; if (ImemReq !== 1'b1 || InstrValid !== 1'b0) begin n_err++; $display("FAIL pre_rst got r=%0b v=%0b exp r=1 v=0", ImemReq, InstrValid); end
        Reset = 1'b1;
        #1;
        n_cmp++; if (ImemReq !== 1'b0) begin n_err++; $display("FAIL rst_gate got %0b exp 0", ImemReq); end
        ImemReady = 1'b1; ImemData = 32'h5555_AAAA;
        tick();
        tick();
        n_cmp++; if (ImemReq !== 1'b0 || Pc !== 32'h0 || InstrCount !== 32'd0 || Instr !== 32'h0 || MisalignErr !== 1'b0) begin
            n_err++; $display("FAIL mid_rst got r=%0b pc=%h c=%0d i=%h m=%0b exp r=0 pc=0 c=0 i=0 m=0", ImemReq, Pc, InstrCount, Instr, MisalignErr);
        end
        ImemReady = 1'b0;
        Reset = 1'b0;
        #1;
        n_cmp++; if (ImemReq !== 1'b1 || ImemAddr !== 32'h0) begin n_err++; $display("FAIL post_rst got r=%0b a=%h exp r=1 a=0", ImemReq, ImemAddr); end
    endtask

    task automatic test_back_to_back();
        ImemReady = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            ImemData = 32'h1000 + 32'(i);
            tick();
            n_cmp++; if (InstrValid !== 1'b1 || Instr !== 32'h1000 + 32'(i)) begin
                n_err++; $display("FAIL b2b_issue%0d got v=%0b i=%h exp v=1 i=%h", i, InstrValid, Instr, 32'h1000 + 32'(i));
            end
            tick();
            n_cmp++; if (Pc !== 32'(4 * i) || InstrCount !== 32'(i) || ImemReq !== 1'b1) begin
                n_err++; $display("FAIL b2b_fetch%0d got pc=%h c=%0d r=%0b exp pc=%h c=%0d r=1", i, Pc, InstrCount, ImemReq, 32'(4 * i), i);
            end
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_wait_stall();
        test_wrap_misalign();
        test_reset_midfetch();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pc_fetch.md
PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 32'h0000_0000, meaning the Pc value loaded on reset.
REQ-002 SHALL have parameter TRAP_VECTOR, default 32'h0000_0100, meaning the redirect target on a misaligned branch (used only with PC_MISALIGN_TRAP_EN).
REQ-003 SHALL have port Clk, input, 1, the single clock; all state updates on the rising edge.
REQ-004 SHALL have port Reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port BranchMux, input, 1, taken-redirect select from the jump-control stage.
REQ-006 SHALL have port BranchTarget, input, 32, redirect address.
REQ-007 SHALL have port Stall, input, 1, downstream hold of the issued instruction.
REQ-008 SHALL have port ImemReady, input, 1, instruction memory data valid for the current request.
REQ-009 SHALL have port ImemData, input, 32, instruction word.
REQ-010 SHALL have port ImemReq, output, 1, fetch request.
REQ-011 SHALL have port ImemAddr, output, 32, fetch address, always equal to Pc.
REQ-012 SHALL have port Pc, output, 32, current program counter.
REQ-013 SHALL have port Instr, output, 32, latched instruction.
REQ-014 SHALL have port InstrValid, output, 1, Instr valid for execute.
REQ-015 SHALL have port InstrCount, output, 32, count of Pc updates since reset.
REQ-016 SHALL have port MisalignErr, output, 1, sticky misaligned-redirect flag (constant 0 without PC_MISALIGN_TRAP_EN).

Function
REQ-017 SHALL implement a two-state FSM: S_FETCH, S_ISSUE.
REQ-018 In S_FETCH: ImemReq=1, InstrValid=0; on ImemReady=1, Instr<=ImemData and next state is S_ISSUE; else remain, address held stable.
REQ-019 In S_ISSUE: ImemReq=0, InstrValid=1; Stall=1 holds state, Pc, Instr unchanged.
REQ-020 In S_ISSUE with Stall=0: Pc<=BranchMux ? BranchTarget : Pc+4; InstrCount increments; next state S_FETCH.
REQ-021 Minimum latency: request to InstrValid is 1 cycle when ImemReady is high in the request cycle.
REQ-022 Pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000); InstrCount likewise wraps.
REQ-023 BranchMux and Stall SHALL be ignored in S_FETCH; Stall and BranchMux both high in S_ISSUE: Stall wins.
REQ-024 ImemReady in S_ISSUE SHALL be ignored.

Reset
REQ-025 Reset=1 at a rising edge SHALL set state S_FETCH, Pc=RESET_VECTOR, Instr=0, InstrCount=0, MisalignErr=0, InstrValid=0, overriding all other inputs.
REQ-026 ImemReq SHALL be gated low while Reset=1; an outstanding request abandoned by reset is not completed.
REQ-027 First request after reset SHALL issue in the cycle following Reset deassertion at address RESET_VECTOR.

Configuration
REQ-028 Macro PC_MISALIGN_TRAP_EN defined: a taken redirect with BranchTarget[1:0]!=0 SHALL load Pc=TRAP_VECTOR and set MisalignErr until reset.
REQ-029 Macro undefined: taken redirect SHALL load {BranchTarget[31:2],2'b00}; MisalignErr tied 0.

Structure
REQ-030 Package pc_pkg SHALL hold the FSM state encoding, PC_STEP=4, and the 32-bit address width constant.
REQ-031 Next-PC selection (increment, redirect, alignment/trap) SHALL live in combinational sub-module pc_next_sel; pc_fetch holds FSM and registers.

Verification
REQ-032 Reset 2 cycles, ImemReady=1 constant -> ImemAddr=0x0 with ImemReq=1 first cycle after reset; InstrValid=1 next cycle.
REQ-033 Sequential flow, BranchMux=0, Stall=0, ImemReady=1 -> Pc 0x0,0x4,0x8 every 2 cycles; InstrCount=3 after third update.
REQ-034 At Pc=0x8, BranchMux=1, BranchTarget=0x40 -> next ImemAddr=0x40.
REQ-035 ImemReady low 3 cycles, then ImemData=0x00A00093 -> ImemAddr stable 4 cycles, Instr=0x00A00093, InstrValid one cycle later; Stall=1 for 2 cycles holds Instr, Pc.
REQ-036 Pc=0xFFFF_FFFC, BranchMux=0 -> Pc=0x0; BranchTarget=0x42 taken -> Pc=0x100, MisalignErr=1 with macro, Pc=0x40 without.
REQ-037 Reset asserted while ImemReady=0 in S_FETCH -> ImemReq=0 during reset, Pc=RESET_VECTOR, InstrCount=0 afterward.
